// File: rtl/instr_fetch_unit_if.sv
// Bundle of the fetch-stage buses: the instruction-memory request channel,
// the decode-side instruction channel, the branch redirect and status/debug.
//
// Handshake semantics:
//   imem channel : imem_req is high and imem_addr stable for every cycle of a
//                  request; the word is taken in the cycle imem_ack is high.
//                  imem_ack with imem_req low has no effect.
//   decode chan. : instr_valid high holds instrucao/pc_out stable until the
//                  cycle instr_ready is also high; that cycle is the transfer,
//                  and branch_taken/branch_offset are meaningful only then.
interface instr_fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instrucao;
  logic [31:0] pc_out;
  logic        instr_valid;
  logic        instr_ready;
  logic        branch_taken;
  logic [31:0] branch_offset;
  logic        fetch_err;
  logic [1:0]  dbg_state;

  // Fetch unit side
  modport master (
    output imem_req, imem_addr,
    input  imem_ack, imem_rdata,
    output instrucao, pc_out, instr_valid,
    input  instr_ready, branch_taken, branch_offset,
    output fetch_err, dbg_state
  );

  // Memory / decode / environment side
  modport slave (
    input  imem_req, imem_addr,
    output imem_ack, imem_rdata,
    input  instrucao, pc_out, instr_valid,
    output instr_ready, branch_taken, branch_offset,
    input  fetch_err, dbg_state
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: holds the PC, reads one word at a time from
// instruction memory, hands it to decode and applies the branch redirect.
// Optional macro FETCH_MISALIGN_CHECK_EN: a misaligned next PC sends the unit
// to the sticky error state instead of being rounded down to a word boundary.
// dbg_state exposes the FSM encoding (IDLE=0, REQ=1, HOLD=2, ERR=3).
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic               clock,
  input  logic               reset,
  instr_fetch_unit_if.master bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2,
    ERR  = 2'd3
  } state_e;

  // A request cycle without ack while the counter already holds this value
  // is the last one allowed.
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pc_out_q, pc_out_d;
  logic [31:0] instr_q, instr_d;
  logic        valid_q, valid_d;
  logic [7:0]  tmo_q, tmo_d;
  logic [31:0] next_pc;

  // Address of the instruction after the one being consumed (mod 2^32).
  assign next_pc = pc_out_q + (bus.branch_taken ? (bus.branch_offset << 1) : 32'd4);

  // State and datapath registers; reset is immediate so req/valid drop at once.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      pc_q     <= RESET_PC;
      pc_out_q <= RESET_PC;
      instr_q  <= 32'h0;
      valid_q  <= 1'b0;
      tmo_q    <= 8'h0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      pc_out_q <= pc_out_d;
      instr_q  <= instr_d;
      valid_q  <= valid_d;
      tmo_q    <= tmo_d;
    end
  end

  // Next-state and datapath updates for the fetch FSM.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    pc_out_d = pc_out_q;
    instr_d  = instr_q;
    valid_d  = valid_q;
    tmo_d    = tmo_q;
    case (state_q)
      IDLE: begin
        tmo_d   = 8'h0;
        state_d = REQ;
      end
      REQ: begin
        if (bus.imem_ack) begin
          // Ack beats the timeout even on the last allowed cycle.
          instr_d  = bus.imem_rdata;
          pc_out_d = pc_q;
          valid_d  = 1'b1;
          tmo_d    = 8'h0;
          state_d  = HOLD;
        end else begin
          tmo_d = tmo_q + 8'd1;
          if (tmo_q == TIMEOUT_LAST) begin
            state_d = ERR;
          end
        end
      end
      HOLD: begin
        if (bus.instr_ready) begin
          valid_d = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
          if (next_pc[1:0] != 2'b00) begin
            state_d = ERR;
          end else begin
            pc_d    = next_pc;
            state_d = REQ;
          end
`else
          pc_d    = next_pc & ~32'h3;
          state_d = REQ;
`endif
        end
      end
      ERR: begin
        valid_d = 1'b0;
      end
      default: begin
        state_d = ERR;
      end
    endcase
  end

  // Outputs are decoded from registered state only.
  always_comb begin
    bus.imem_req    = (state_q == REQ);
    bus.imem_addr   = pc_q;
    bus.instrucao   = instr_q;
    bus.pc_out      = pc_out_q;
    bus.instr_valid = valid_q;
    bus.fetch_err   = (state_q == ERR);
    bus.dbg_state   = state_q;
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed vector table, multi-cycle corner
// sequences, and a randomized run against a transaction-level model.
module tb_instr_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  instr_fetch_unit_if bus ();

  instr_fetch_unit #(.RESET_PC(RST_PC), .TIMEOUT_CYCLES(16)) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  // Clock and global watchdog
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [31:0] rdata;
    logic        taken;
    logic [31:0] offset;
    logic [31:0] exp_pc;
    logic [31:0] exp_next;
    int          hold;
  } vec_t;

  vec_t vecs[8];

  // Scoreboard for the random run
  logic [31:0] exp_q[$];
  logic [31:0] exp_pc_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic wait_req();
    int n = 0;
    while (bus.imem_req !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("wait_req", 32'(bus.imem_req), 32'd1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.imem_ack = 1'b0;
    bus.instr_ready = 1'b0;
    bus.branch_taken = 1'b0;
    #1;
    chk("rst_req", 32'(bus.imem_req), 32'd0);
    chk("rst_valid", 32'(bus.instr_valid), 32'd0);
    chk("rst_err", 32'(bus.fetch_err), 32'd0);
    chk("rst_instr", bus.instrucao, 32'd0);
    chk("rst_pc_out", bus.pc_out, RST_PC);
    chk("rst_addr", bus.imem_addr, RST_PC);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("idle_req", 32'(bus.imem_req), 32'd0);
  endtask

  // One fetch: ack one cycle after req, optional hold cycles with ready=0,
  // then consume with the given branch inputs.
  task automatic do_fetch(input logic [31:0] rdata, input logic taken,
                          input logic [31:0] off, input logic [31:0] exp_pc,
                          input logic [31:0] exp_next, input int hold,
                          input bit exp_err);
    wait_req();
    chk("req_addr", bus.imem_addr, exp_pc);
    bus.imem_ack = 1'b0;
    @(negedge clk);
    chk("req_held", 32'(bus.imem_req), 32'd1);
    chk("req_addr_held", bus.imem_addr, exp_pc);
    bus.imem_ack = 1'b1;
    bus.imem_rdata = rdata;
    @(negedge clk);
    bus.imem_ack = 1'b0;
    chk("valid_after_ack", 32'(bus.instr_valid), 32'd1);
    chk("req_low_in_hold", 32'(bus.imem_req), 32'd0);
    chk("instr", bus.instrucao, rdata);
    chk("pc_out", bus.pc_out, exp_pc);
    for (int h = 0; h < hold; h++) begin
      bus.imem_rdata = $urandom;
      bus.instr_ready = 1'b0;
      bus.branch_taken = 1'($urandom_range(0, 1));
      bus.branch_offset = $urandom;
      @(negedge clk);
      chk("hold_valid", 32'(bus.instr_valid), 32'd1);
      chk("hold_instr", bus.instrucao, rdata);
      chk("hold_pc_out", bus.pc_out, exp_pc);
    end
    bus.instr_ready = 1'b1;
    bus.branch_taken = taken;
    bus.branch_offset = off;
    @(negedge clk);
    bus.instr_ready = 1'b0;
    bus.branch_taken = 1'b0;
    chk("valid_drop", 32'(bus.instr_valid), 32'd0);
    if (exp_err) begin
      chk("misalign_err", 32'(bus.fetch_err), 32'd1);
      chk("misalign_req", 32'(bus.imem_req), 32'd0);
    end else begin
      chk("next_req", 32'(bus.imem_req), 32'd1);
      chk("next_addr", bus.imem_addr, exp_next);
      chk("no_err", 32'(bus.fetch_err), 32'd0);
    end
  endtask

  // Timeout sequence: 16 request cycles, ack only on the 16th when ack_last.
  task automatic timeout_seq(input bit ack_last);
    wait_req();
    for (int i = 1; i <= 16; i++) begin
      if (i > 1) @(negedge clk);
      chk("to_req", 32'(bus.imem_req), 32'd1);
      chk("to_err_early", 32'(bus.fetch_err), 32'd0);
      bus.imem_ack = ack_last && (i == 16);
      bus.imem_rdata = 32'hCAFE_0001;
    end
    @(negedge clk);
    bus.imem_ack = 1'b0;
    if (ack_last) begin
      chk("to_ack_wins_valid", 32'(bus.instr_valid), 32'd1);
      chk("to_ack_wins_err", 32'(bus.fetch_err), 32'd0);
      chk("to_ack_wins_instr", bus.instrucao, 32'hCAFE_0001);
    end else begin
      chk("to_err", 32'(bus.fetch_err), 32'd1);
      chk("to_err_req", 32'(bus.imem_req), 32'd0);
      chk("to_err_valid", 32'(bus.instr_valid), 32'd0);
    end
  endtask

  initial begin
    int          wait_cnt;
    int          o;
    bit          prev_ack;
    bit          prev_ready;
    logic [31:0] model_pc;
    logic [31:0] cur_pc;

    vecs[0] = '{32'h0000_0013, 1'b0, 32'h0,         32'h0000_0000, 32'h0000_0004, 0};
    vecs[1] = '{32'h0010_0093, 1'b0, 32'h0,         32'h0000_0004, 32'h0000_0008, 0};
    vecs[2] = '{32'hFE00_0EE3, 1'b1, 32'hFFFF_FFFC, 32'h0000_0008, 32'h0000_0000, 0};
    vecs[3] = '{32'h0020_8113, 1'b0, 32'h0,         32'h0000_0000, 32'h0000_0004, 5};
    vecs[4] = '{32'h2000_0063, 1'b1, 32'h0000_0100, 32'h0000_0004, 32'h0000_0204, 0};
    vecs[5] = '{32'hDEAD_BEEF, 1'b1, 32'hFFFF_FEFC, 32'h0000_0204, 32'hFFFF_FFFC, 0};
    vecs[6] = '{32'h1234_5678, 1'b0, 32'h0,         32'hFFFF_FFFC, 32'h0000_0000, 0};
    vecs[7] = '{32'h0040_0113, 1'b0, 32'h0,         32'h0000_0000, 32'h0000_0004, 0};

    bus.imem_ack = 1'b0;
    bus.imem_rdata = 32'h0;
    bus.instr_ready = 1'b0;
    bus.branch_taken = 1'b0;
    bus.branch_offset = 32'h0;

    // Reset and directed vector table
    do_reset();
    foreach (vecs[i]) begin
      do_fetch(vecs[i].rdata, vecs[i].taken, vecs[i].offset, vecs[i].exp_pc,
               vecs[i].exp_next, vecs[i].hold, 1'b0);
    end

    // Odd halfword offset from pc 4: 4 + 2 = 6
`ifdef FETCH_MISALIGN_CHECK_EN
    do_fetch(32'h0000_1063, 1'b1, 32'h1, 32'h4, 32'h0, 0, 1'b1);
`else
    do_fetch(32'h0000_1063, 1'b1, 32'h1, 32'h4, 32'h4, 0, 1'b0);
`endif

    // Randomized run against the transaction model
    do_reset();
    model_pc = RST_PC;
    wait_cnt = 0;
    prev_ack = 1'b0;
    prev_ready = 1'b0;
    exp_q.delete();
    exp_pc_q.delete();
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      if (prev_ack) begin
        chk("rnd_valid_after_ack", 32'(bus.instr_valid), 32'd1);
        chk("rnd_req_drop", 32'(bus.imem_req), 32'd0);
      end
      if (prev_ready) begin
        chk("rnd_valid_drop", 32'(bus.instr_valid), 32'd0);
        chk("rnd_req_after_ready", 32'(bus.imem_req), 32'd1);
      end
      if (bus.imem_req) chk("rnd_addr", bus.imem_addr, model_pc);
      if (bus.instr_valid) begin
        if (exp_q.size() == 0) begin
          chk("rnd_unexpected_valid", 32'(bus.instr_valid), 32'd0);
        end else begin
          chk("rnd_instr", bus.instrucao, exp_q[0]);
          chk("rnd_pc_out", bus.pc_out, exp_pc_q[0]);
        end
      end
      chk("rnd_no_err", 32'(bus.fetch_err), 32'd0);

      prev_ack = 1'b0;
      prev_ready = 1'b0;
      bus.imem_ack = 1'b0;
      bus.imem_rdata = $urandom;
      bus.instr_ready = 1'b0;
      o = $urandom_range(0, 127) - 64;
`ifdef FETCH_MISALIGN_CHECK_EN
      o = o & ~1;
`endif
      bus.branch_taken = 1'($urandom_range(0, 1));
      bus.branch_offset = 32'(o);
      if (bus.imem_req) begin
        if (wait_cnt >= 8 || $urandom_range(0, 2) == 0) begin
          bus.imem_ack = 1'b1;
          exp_q.push_back(bus.imem_rdata);
          exp_pc_q.push_back(model_pc);
          prev_ack = 1'b1;
          wait_cnt = 0;
        end else begin
          wait_cnt++;
        end
      end else begin
        bus.imem_ack = 1'($urandom_range(0, 1));
        if (!bus.instr_valid) bus.instr_ready = 1'($urandom_range(0, 1));
      end
      if (bus.instr_valid && exp_q.size() > 0 && $urandom_range(0, 1) == 1) begin
        bus.instr_ready = 1'b1;
        prev_ready = 1'b1;
        cur_pc = exp_pc_q.pop_front();
        void'(exp_q.pop_front());
        model_pc = cur_pc + (bus.branch_taken ? 32'(o * 2) : 32'd4);
        model_pc = model_pc - (model_pc % 4);
      end
    end
    @(negedge clk);
    bus.imem_ack = 1'b0;
    bus.instr_ready = 1'b0;

    // Timeout: ack on the 16th cycle wins, then 16 cycles without ack errors
    do_reset();
    timeout_seq(1'b1);
    bus.instr_ready = 1'b1;
    bus.branch_taken = 1'b0;
    @(negedge clk);
    bus.instr_ready = 1'b0;
    chk("to_next_addr", bus.imem_addr, 32'h4);
    timeout_seq(1'b0);
    bus.imem_ack = 1'b1;
    repeat (3) @(negedge clk);
    bus.imem_ack = 1'b0;
    chk("err_sticky", 32'(bus.fetch_err), 32'd1);
    chk("err_no_req", 32'(bus.imem_req), 32'd0);
    do_reset();
    chk("err_cleared_addr", bus.imem_addr, RST_PC);

    // Reset while a request is being acknowledged
    wait_req();
    bus.imem_ack = 1'b1;
    bus.imem_rdata = 32'h5555_AAAA;
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_req", 32'(bus.imem_req), 32'd0);
    chk("async_rst_valid", 32'(bus.instr_valid), 32'd0);
    @(negedge clk);
    bus.imem_ack = 1'b0;
    rst = 1'b0;
    do_fetch(32'h0000_0093, 1'b0, 32'h0, RST_PC, RST_PC + 32'd4, 0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
